priv_ext_csr_sequencer: RTL and testbench

// - Sequences privileged-unit CSR accesses onto NUM_EXT extension CSR files over the priv/ext CSR handshake.
// - Broadcasts address, finds the owning extension via ack, captures the old value and computes the new one.
// - Issues a single-cycle write strobe to the owner only, then returns a one-cycle response to the priv unit.
// - Sits between the main privileged CSR file and the extension CSR files.

---
 rtl/priv_ext_csr_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_priv_ext_csr_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/priv_ext_csr_sequencer.sv
// Sequences privileged-unit CSR accesses onto NUM_EXT extension CSR files.
// Flow: IDLE -> PROBE -> (WRITE) -> RESP -> IDLE. The done pulse and its response
// fields are registered on RESP exit, so they appear the cycle after RESP.
// Optional feature: define PRIV_EXT_CONFLICT_CHECK_EN to flag multi-owner acks
// as invalid and expose a sticky conflict output.
module priv_ext_csr_sequencer #(
  parameter int unsigned NUM_EXT = 2,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req,
  input  logic [1:0]             op,
  input  logic [11:0]            csr_addr,
  input  logic [31:0]            wdata,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            rdata,
  output logic                   invalid,
  output logic                   no_owner,
  output logic [11:0]            ext_csr_addr,
  output logic [31:0]            ext_value_in,
  output logic [NUM_EXT-1:0]     ext_csr_active,
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
  output logic                   conflict,
`endif
  input  logic [NUM_EXT-1:0]     ext_ack,
  input  logic [NUM_EXT-1:0]     ext_invalid,
  input  logic [32*NUM_EXT-1:0]  ext_value_out
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StProbe, StWrite, StResp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [11:0]         addr_q, addr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [31:0]         old_q, old_d;
  logic                inv_q, inv_d;
  logic                nown_q, nown_d;
  logic [31:0]         new_q, new_d;
  logic [NUM_EXT-1:0]  active_q, active_d;
  logic                done_q, done_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                invalid_q, invalid_d;
  logic                no_owner_q, no_owner_d;
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
  logic                conflict_q, conflict_d;
`endif

  logic [31:0]         ack_val;
  logic                ack_inv;
  logic [NUM_EXT-1:0]  ack_sel;
  logic                ack_any;
  logic                ack_multi;
  logic                probe_inv;
  logic                wr_needed;
  logic [31:0]         new_val;

  // Lowest-index acking extension owns the CSR; descending scan lets it win.
  always_comb begin
    ack_val = '0;
    ack_inv = 1'b0;
    ack_sel = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (ext_ack[i]) begin
        ack_val    = ext_value_out[32*i +: 32];
        ack_inv    = ext_invalid[i];
        ack_sel    = '0;
        ack_sel[i] = 1'b1;
      end
    end
    ack_any   = |ext_ack;
    ack_multi = |(ext_ack & (ext_ack - NUM_EXT'(1)));
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
    probe_inv = ack_inv | ack_multi;
`else
    probe_inv = ack_inv;
`endif
    // Set/clear with an empty mask cannot change the CSR, so it never strobes.
    wr_needed = (op_q == 2'b00) || (((op_q == 2'b01) || (op_q == 2'b10)) && (wdata_q != '0));
    unique case (op_q)
      2'b00:   new_val = wdata_q;
      2'b01:   new_val = ack_val | wdata_q;
      2'b10:   new_val = ack_val & ~wdata_q;
      default: new_val = ack_val;
    endcase
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    old_d      = old_q;
    inv_d      = inv_q;
    nown_d     = nown_q;
    new_d      = new_q;
    active_d   = '0;
    done_d     = 1'b0;
    rdata_d    = rdata_q;
    invalid_d  = invalid_q;
    no_owner_d = no_owner_q;
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
    conflict_d = conflict_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          op_d    = op;
          addr_d  = csr_addr;
          wdata_d = wdata;
          cnt_d   = '0;
          state_d = StProbe;
        end
      end
      StProbe: begin
        if (ack_any) begin
          old_d  = ack_val;
          inv_d  = probe_inv;
          nown_d = 1'b0;
          new_d  = new_val;
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
          conflict_d = conflict_q | ack_multi;
`endif
          if (wr_needed && !probe_inv) begin
            active_d = ack_sel;
            state_d  = StWrite;
          end else begin
            state_d = StResp;
          end
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          old_d   = '0;
          inv_d   = 1'b1;
          nown_d  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrite: begin
        state_d = StResp;
      end
      StResp: begin
        done_d     = 1'b1;
        rdata_d    = old_q;
        invalid_d  = inv_q;
        no_owner_d = nown_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // All state, with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      op_q       <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      old_q      <= '0;
      inv_q      <= 1'b0;
      nown_q     <= 1'b0;
      new_q      <= '0;
      active_q   <= '0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      invalid_q  <= 1'b0;
      no_owner_q <= 1'b0;
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
      conflict_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      old_q      <= old_d;
      inv_q      <= inv_d;
      nown_q     <= nown_d;
      new_q      <= new_d;
      active_q   <= active_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      invalid_q  <= invalid_d;
      no_owner_q <= no_owner_d;
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
      conflict_q <= conflict_d;
`endif
    end
  end

  // Reset aborts at once: strobe and done are masked in the reset cycle itself.
  assign busy           = (state_q != StIdle);
  assign done           = done_q & ~RST;
  assign ext_csr_active = active_q & {NUM_EXT{~RST}};
  assign rdata          = rdata_q;
  assign invalid        = invalid_q;
  assign no_owner       = no_owner_q;
  assign ext_csr_addr   = addr_q;
  assign ext_value_in   = new_q;
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
  assign conflict       = conflict_q;
`endif

endmodule

// File: tb/tb_priv_ext_csr_sequencer.sv
// Bench for priv_ext_csr_sequencer: transaction-level model fills per-cycle
// expectations; a negedge compare process checks every cycle.
module tb_priv_ext_csr_sequencer;

  localparam int TIMEOUT = 4;
  localparam int MAXC    = 512;
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
  localparam bit ConfEn = 1'b1;
`else
  localparam bit ConfEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  op = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, invalid, no_owner;
  logic [31:0] rdata, ext_value_in;
  logic [11:0] ext_csr_addr;
  logic [1:0]  ext_csr_active;
  logic [1:0]  ext_ack = '0;
  logic [1:0]  ext_invalid = '0;
  logic [63:0] ext_value_out = '0;
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
  logic        conflict;
`endif

  priv_ext_csr_sequencer #(.NUM_EXT(2), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .req(req), .op(op), .csr_addr(csr_addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .invalid(invalid), .no_owner(no_owner),
    .ext_csr_addr(ext_csr_addr), .ext_value_in(ext_value_in),
    .ext_csr_active(ext_csr_active),
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
    .conflict(conflict),
`endif
    .ext_ack(ext_ack), .ext_invalid(ext_invalid), .ext_value_out(ext_value_out)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations, default idle/zero.
  bit        exp_busy[MAXC];
  bit        exp_done[MAXC];
  bit [1:0]  exp_active[MAXC];
  bit [31:0] exp_vin[MAXC];
  bit [11:0] exp_addr[MAXC];
  bit [31:0] exp_rdata[MAXC];
  bit        exp_inv[MAXC];
  bit        exp_nown[MAXC];
  bit        exp_conf[MAXC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Transaction model: request issued in cycle c with extension responses held.
  task automatic model_txn(input int c, input logic [1:0] op_m, input logic [11:0] a,
                           input logic [31:0] wd, input logic [1:0] ack,
                           input logic [1:0] inv, input logic [31:0] v0,
                           input logic [31:0] v1, output int lat);
    int owner, nack;
    logic [31:0] old, nv, r;
    logic iv, no, wr, cf;
    owner = -1; nack = 0; cf = 1'b0; wr = 1'b0; nv = '0; old = '0;
    for (int i = 0; i < 2; i++) begin
      if (ack[i]) begin
        nack++;
        if (owner < 0) owner = i;
      end
    end
    if (owner < 0) begin
      lat = TIMEOUT + 2; r = '0; iv = 1'b1; no = 1'b1;
    end else begin
      old = (owner == 0) ? v0 : v1;
      r = old; no = 1'b0; iv = inv[owner];
      if (ConfEn && nack > 1) begin iv = 1'b1; cf = 1'b1; end
      case (op_m)
        2'd0: nv = wd;
        2'd1: nv = old | wd;
        2'd2: nv = old & ~wd;
        default: nv = old;
      endcase
      wr  = !iv && (op_m == 2'd0 || (op_m != 2'd3 && wd != 0));
      lat = wr ? 4 : 3;
    end
    for (int k = 1; k < lat; k++) exp_busy[c+k] = 1'b1;
    exp_done[c+lat] = 1'b1;
    if (wr) begin
      exp_active[c+2] = 2'(1 << owner);
      exp_vin[c+2]    = nv;
      exp_addr[c+2]   = a;
    end
    for (int j = c + lat; j < MAXC; j++) begin
      exp_rdata[j] = r; exp_inv[j] = iv; exp_nown[j] = no;
      if (cf) exp_conf[j] = 1'b1;
    end
  endtask

  // Reset driven during cycle r: nothing fires from r, state clears from r+1.
  task automatic model_reset(input int r);
    for (int j = r; j < MAXC; j++) begin
      exp_active[j] = '0; exp_done[j] = 1'b0;
      if (j > r) begin
        exp_busy[j] = 1'b0; exp_rdata[j] = '0; exp_inv[j] = 1'b0;
        exp_nown[j] = 1'b0; exp_conf[j] = 1'b0;
      end
    end
  endtask

  // Compare process.
  always @(negedge CLK) begin
    if (cyc < MAXC) begin
      chk("done", done, exp_done[cyc]);
      chk("strobe", ext_csr_active, exp_active[cyc]);
      if (!RST) begin
        chk("busy", busy, exp_busy[cyc]);
        if (exp_active[cyc] != 0) begin
          chk("value_in", ext_value_in, exp_vin[cyc]);
          chk("ext_addr", ext_csr_addr, exp_addr[cyc]);
        end
        chk("rdata", rdata, exp_rdata[cyc]);
        chk("invalid", invalid, exp_inv[cyc]);
        chk("no_owner", no_owner, exp_nown[cyc]);
`ifdef PRIV_EXT_CONFLICT_CHECK_EN
        if (!exp_busy[cyc]) chk("conflict", conflict, exp_conf[cyc]);
`endif
      end
    end
  end

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [11:0] a, input logic [31:0] wd,
                       input logic [1:0] ack, input logic [1:0] inv,
                       input logic [31:0] v0, input logic [31:0] v1,
                       output int c, output int lat);
    c = cyc;
    op = o; csr_addr = a; wdata = wd;
    ext_ack = ack; ext_invalid = inv; ext_value_out = {v1, v0};
    req = 1'b1;
    model_txn(c, o, a, wd, ack, inv, v0, v1, lat);
    @(posedge CLK);
    #1;
    req = 1'b0;
  endtask

  int c, lat;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    goto_cyc(3);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ext_addr", ext_csr_addr, 12'h0);
    chk("rst_value_in", ext_value_in, 32'h0);
    goto_cyc(cyc + 1);

    // Read-only on ext1.
    issue(2'b11, 12'h7C0, 32'h0, 2'b10, 2'b00, 32'h0, 32'hDEADBEEF, c, lat);
    goto_cyc(c + 3); @(negedge CLK);
    chk("pin_read_done", done, 1'b1);
    chk("pin_read_rdata", rdata, 32'hDEADBEEF);
    goto_cyc(c + lat + 1);

    // Set bits on ext0.
    issue(2'b01, 12'h300, 32'h0000_000F, 2'b01, 2'b00, 32'h0000_00F0, 32'h0, c, lat);
    goto_cyc(c + 2); @(negedge CLK);
    chk("pin_rs_strobe", ext_csr_active, 2'b01);
    chk("pin_rs_value", ext_value_in, 32'h0000_00FF);
    goto_cyc(c + 4); @(negedge CLK);
    chk("pin_rs_done", done, 1'b1);
    chk("pin_rs_rdata", rdata, 32'h0000_00F0);
    goto_cyc(c + lat + 1);

    // Clear with zero mask, invalid owner, RW to ext1, real clear.
    issue(2'b10, 12'h301, 32'h0, 2'b01, 2'b00, 32'h1234_5678, 32'h0, c, lat);
    goto_cyc(c + lat + 1);
    issue(2'b00, 12'h302, 32'hFFFF_0000, 2'b01, 2'b01, 32'h0000_1111, 32'h0, c, lat);
    goto_cyc(c + 3); @(negedge CLK);
    chk("pin_inv_invalid", invalid, 1'b1);
    goto_cyc(c + lat + 1);
    issue(2'b00, 12'h7C1, 32'h0000_AAAA, 2'b10, 2'b00, 32'h0, 32'h0000_0005, c, lat);
    goto_cyc(c + lat + 1);
    issue(2'b10, 12'h7C2, 32'h0000_000F, 2'b01, 2'b10, 32'h0000_00FF, 32'h0, c, lat);
    goto_cyc(c + lat + 1);

    // Timeout with a stray request while busy.
    issue(2'b00, 12'h123, 32'h5555_5555, 2'b00, 2'b00, 32'h0, 32'h0, c, lat);
    goto_cyc(c + 2);
    req = 1'b1; csr_addr = 12'h456; op = 2'b11;
    goto_cyc(c + 3);
    req = 1'b0;
    goto_cyc(c + 6); @(negedge CLK);
    chk("pin_to_done", done, 1'b1);
    chk("pin_to_no_owner", no_owner, 1'b1);
    chk("pin_to_rdata", rdata, 32'h0);
    goto_cyc(c + lat + 1);

    // Both extensions ack a RW.
    issue(2'b00, 12'h7C3, 32'h0000_0042, 2'b11, 2'b00, 32'h0000_0010, 32'h0000_0020, c, lat);
    goto_cyc(c + lat + 1);

    // Reset in the WRITE cycle, then a normal request.
    issue(2'b00, 12'h7C4, 32'h0000_0022, 2'b01, 2'b00, 32'h0000_0011, 32'h0, c, lat);
    goto_cyc(c + 2);
    RST = 1'b1;
    model_reset(c + 2);
    @(negedge CLK);
    chk("pin_rst_strobe", ext_csr_active, 2'b00);
    goto_cyc(c + 3);
    RST = 1'b0;
    goto_cyc(c + 4);
    issue(2'b01, 12'h7C5, 32'h0000_0100, 2'b10, 2'b00, 32'h0, 32'h0000_0001, c, lat);
    goto_cyc(c + 2); @(negedge CLK);
    chk("pin_post_rst_value", ext_value_in, 32'h0000_0101);
    goto_cyc(c + lat + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
